// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry constants, fetch states and pixel type
package sprite_pkg;

  localparam int SPR_W  = 16;
  localparam int SPR_H  = 28;
  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// rtl/sprite_line_buffer.sv - one sprite row of rgb4 pixels, sync write, combinational read
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int DEPTH = SPR_W,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  rgb4_t         wdata,
  input  logic [IW-1:0] raddr,
  output rgb4_t         rdata
);

  rgb4_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - fetches next line's sprite row during hblank, streams pixels by hcount
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENCY_EN.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int         SPR_W   = sprite_pkg::SPR_W,
  parameter int         SPR_H   = sprite_pkg::SPR_H,
  parameter int         ADDR_W  = sprite_pkg::ADDR_W,
  parameter int         V_TOTAL = 525,
  parameter logic [3:0] KEY     = 4'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              line_start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_r,
  input  logic [7:0]        rom_g,
  input  logic [7:0]        rom_b,
  output logic              busy,
  output logic              fetch_done,
  output logic              pix_valid,
  output logic [3:0]        pix_r,
  output logic [3:0]        pix_g,
  output logic [3:0]        pix_b
);

  localparam int IW = $clog2(SPR_W);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  fetch_state_t       state;
  logic [IW-1:0]      idx;
  logic [9:0]         x_lat;
  logic               row_hit;
  logic [9:0]         nxt;
  logic signed [10:0] row;
  logic signed [10:0] col;
  logic               row_in_range;
  logic               hit_pix;
  logic               transparent;
  logic [ADDR_W-1:0]  base;
  logic               we;
  logic [IW-1:0]      waddr;
  rgb4_t              wdata;
  rgb4_t              rdata;
  logic               unused_hi;

  assign unused_hi = ^{rom_r[7:4], rom_g[7:4], rom_b[7:4]};

  assign nxt          = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
  assign row          = $signed({1'b0, nxt}) - $signed({1'b0, sprite_y});
  assign row_in_range = (row >= 11'sd0) && (row < 11'(SPR_H));
  assign base         = ADDR_W'(row * SPR_W);

  // ROM data lags the address by one cycle, so FETCH writes the previous slot and DRAIN the last one.
  assign we    = !line_start && ((state == FETCH && idx != '0) || state == DRAIN);
  assign waddr = (state == DRAIN) ? idx : idx - IW'(1);
  assign wdata = {rom_r[3:0], rom_g[3:0], rom_b[3:0]};

  assign col     = $signed({1'b0, hcount}) - $signed({1'b0, x_lat});
  assign hit_pix = row_hit && (col >= 11'sd0) && (col < 11'(SPR_W));

  assign transparent = TRANSP && (rdata.r == KEY) && (rdata.g == KEY) && (rdata.b == KEY);

  sprite_line_buffer #(.DEPTH(SPR_W), .IW(IW)) u_buf (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (col[IW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      rom_addr   <= '0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      row_hit    <= 1'b0;
      x_lat      <= '0;
      pix_valid  <= 1'b0;
      pix_r      <= '0;
      pix_g      <= '0;
      pix_b      <= '0;
    end else begin
      fetch_done <= 1'b0;
      // A new line_start always wins, which also aborts any fetch still in flight.
      if (line_start) begin
        x_lat   <= sprite_x;
        row_hit <= row_in_range;
        idx     <= '0;
        if (row_in_range) begin
          state    <= FETCH;
          busy     <= 1'b1;
          rom_addr <= base;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (idx == IW'(SPR_W - 1)) begin
              state      <= DRAIN;
              fetch_done <= 1'b1;
            end else begin
              idx      <= idx + IW'(1);
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
          DRAIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end

      pix_valid <= hit_pix && !transparent;
      if (hit_pix && !transparent) begin
        pix_r <= rdata.r;
        pix_g <= rdata.g;
        pix_b <= rdata.b;
      end else begin
        pix_r <= '0;
        pix_g <= '0;
        pix_b <= '0;
      end
    end
  end

endmodule
